// File: rtl/divider_datapath_pkg.sv
// Shared definitions for the sequential divider: operand width and the
// R write-back source encoding driven by the controller.
package divider_datapath_pkg;

   localparam int unsigned DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'b00,
      SEL_ALU  = 2'b01,
      SEL_CLR  = 2'b10,
      SEL_KEEP = 2'b11
   } sel_e;

endpackage : divider_datapath_pkg

// File: rtl/divider_datapath_if.sv
// Control/operand/result bundle between the divider controller (master)
// and the shift-subtract datapath (slave).
interface divider_datapath_if
   import divider_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
);
   logic             load;
   logic             add;
   logic             shift;
   logic             inbit;
   sel_e             sel;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             sign;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output load, add, shift, inbit, sel, dividend, divisor,
      input  sign, quotient, remainder
   );

   modport slave (
      input  load, add, shift, inbit, sel, dividend, divisor,
      output sign, quotient, remainder
   );

endinterface : divider_datapath_if

// File: rtl/divider_addsub.sv
// W-bit adder/subtractor: y = add ? a + b : a - b (modulo 2^W).
module divider_addsub #(
   parameter int unsigned W = 10
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         add,
   output logic [W-1:0] y
);

   assign y = add ? (a + b) : (a - b);

endmodule : divider_addsub

// File: rtl/divider_datapath.sv
// Restoring shift-subtract datapath: holds D, partial remainder R and the
// quotient/dividend shift register Q, stepped by the divider controller.
module divider_datapath
   import divider_datapath_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   divider_datapath_if.slave  bus
);

   localparam int unsigned AW = WIDTH + 2;

   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;

   logic [AW-1:0]    r_ext;
   logic [AW-1:0]    d_ext;
   logic [AW-1:0]    alu;
   logic [AW-1:0]    trial;

   logic [WIDTH:0]   r_sel;
   logic [WIDTH-1:0] q_sel;
   logic             unused_c;

   assign r_ext = AW'(r_q);
   assign d_ext = AW'(d_q);

   divider_addsub #(.W(AW)) u_alu (
      .a   (r_ext),
      .b   (d_ext),
      .add (bus.add),
      .y   (alu)
   );

   // Dedicated trial subtract so sign depends on registers only.
   divider_addsub #(.W(AW)) u_sign (
      .a   (r_ext),
      .b   (d_ext),
      .add (1'b0),
      .y   (trial)
   );

   // R/Q write-back source selection; load overrides sel.
   always_comb begin
      r_sel = r_q;
      q_sel = q_q;
      case (bus.sel)
         SEL_HOLD: r_sel = r_q;
         SEL_ALU:  r_sel = alu[WIDTH:0];
         SEL_CLR:  r_sel = '0;
         SEL_KEEP: r_sel = r_q;
         default:  r_sel = r_q;
      endcase
      if (bus.load) begin
         r_sel = '0;
         q_sel = bus.dividend;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
         q_q <= '0;
         d_q <= '0;
      end else begin
         if (bus.load) begin
            d_q <= bus.divisor;
         end
         // R[WIDTH] of the write-back is always 0 here, so dropping it is lossless.
         if (bus.shift) begin
            r_q <= {r_sel[WIDTH-1:0], q_sel[WIDTH-1]};
            q_q <= {q_sel[WIDTH-2:0], bus.inbit};
         end else begin
            r_q <= r_sel;
            q_q <= q_sel;
         end
      end
   end

   assign bus.sign      = trial[AW-1];
   assign bus.quotient  = q_q;
   assign bus.remainder = r_q[WIDTH:1];

   assign unused_c = ^{alu[AW-1], trial[AW-2:0]};

endmodule : divider_datapath

// File: tb/tb_divider_datapath.sv
// Self-checking bench for divider_datapath: drives the controller sequence
// and compares results against plain integer division.
module tb_divider_datapath;
   import divider_datapath_pkg::*;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   divider_datapath_if #(.WIDTH(W)) bus ();

   divider_datapath #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_q(input logic [7:0] a, input logic [7:0] b);
      return (b == 8'd0) ? 8'hFF : 8'(a / b);
   endfunction

   function automatic logic [7:0] model_r(input logic [7:0] a, input logic [7:0] b);
      return (b == 8'd0) ? a : 8'(a % b);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      bus.load  = 1'b0;
      bus.add   = 1'b0;
      bus.shift = 1'b0;
      bus.inbit = 1'b0;
      bus.sel   = SEL_HOLD;
   endtask

   task automatic start_div(input logic [7:0] a, input logic [7:0] b);
      bus.load     = 1'b1;
      bus.shift    = 1'b1;
      bus.sel      = SEL_CLR;
      bus.add      = 1'b0;
      bus.inbit    = 1'b0;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      idle_ctrl();
      bus.dividend = 8'($urandom);
      bus.divisor  = 8'($urandom);
   endtask

   // One iteration: trial subtract, then restore+shift0 or keep+shift1.
   task automatic step(output logic s);
      bus.sel   = SEL_ALU;
      bus.add   = 1'b0;
      bus.shift = 1'b0;
      #1 s = bus.sign;
      tick();
      if (s) begin
         bus.sel   = SEL_ALU;
         bus.add   = 1'b1;
         bus.inbit = 1'b0;
      end else begin
         bus.sel   = SEL_KEEP;
         bus.add   = 1'b0;
         bus.inbit = 1'b1;
      end
      bus.shift = 1'b1;
      tick();
      idle_ctrl();
   endtask

   task automatic iterate(output logic [7:0] q, output logic [7:0] r, output logic [7:0] signs);
      logic s;
      for (int i = 0; i < 8; i++) begin
         step(s);
         signs[7-i] = s;
      end
      q = bus.quotient;
      r = bus.remainder;
   endtask

   task automatic check_div(input string name, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] q, r, signs, eq, er;
      eq = model_q(a, b);
      er = model_r(a, b);
      start_div(a, b);
      iterate(q, r, signs);
      n_checks++;
      if (q !== eq) begin
         n_fail++;
         $display("FAIL %s quotient %0d/%0d: got %0d expected %0d", name, a, b, q, eq);
      end
      n_checks++;
      if (r !== er) begin
         n_fail++;
         $display("FAIL %s remainder %0d/%0d: got %0d expected %0d", name, a, b, r, er);
      end
      // sign must be set exactly on iterations producing a 0 quotient bit
      n_checks++;
      if (signs !== ~eq) begin
         n_fail++;
         $display("FAIL %s sign pattern %0d/%0d: got %b expected %b", name, a, b, signs, ~eq);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_ctrl();
      bus.dividend = 8'hA5;
      bus.divisor  = 8'h3C;
      #3;
      tick();
      n_checks++;
      if (bus.quotient !== 8'd0) begin
         n_fail++;
         $display("FAIL reset quotient: got %h expected 00", bus.quotient);
      end
      n_checks++;
      if (bus.remainder !== 8'd0) begin
         n_fail++;
         $display("FAIL reset remainder: got %h expected 00", bus.remainder);
      end
      n_checks++;
      if (bus.sign !== 1'b0) begin
         n_fail++;
         $display("FAIL reset sign: got %b expected 0", bus.sign);
      end
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      check_div("d100_7", 8'd100, 8'd7);
      check_div("d255_1", 8'd255, 8'd1);
      check_div("d5_10", 8'd5, 8'd10);
      check_div("d0_0", 8'd0, 8'd0);
      check_div("d200_0", 8'd200, 8'd0);
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         check_div("random", a, b);
      end
   endtask

   task automatic test_reset_mid();
      logic s;
      start_div(8'd100, 8'd7);
      for (int i = 0; i < 3; i++) step(s);
      bus.sel = SEL_ALU;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (bus.quotient !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid quotient: got %h expected 00", bus.quotient);
      end
      n_checks++;
      if (bus.remainder !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid remainder: got %h expected 00", bus.remainder);
      end
      n_checks++;
      if (bus.sign !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid sign: got %b expected 0", bus.sign);
      end
      idle_ctrl();
      tick();
      #2 reset = 1'b1;
      tick();
      check_div("after_reset", 8'd100, 8'd7);
   endtask

   task automatic test_load_wins();
      logic [7:0] q, r, signs;
      check_div("pre_load", 8'd100, 8'd7);
      bus.load     = 1'b1;
      bus.sel      = SEL_ALU;
      bus.add      = 1'b1;
      bus.shift    = 1'b0;
      bus.inbit    = 1'b1;
      bus.dividend = 8'h5A;
      bus.divisor  = 8'h33;
      tick();
      idle_ctrl();
      n_checks++;
      if (bus.remainder !== 8'd0) begin
         n_fail++;
         $display("FAIL load_wins remainder: got %h expected 00", bus.remainder);
      end
      n_checks++;
      if (bus.quotient !== 8'h5A) begin
         n_fail++;
         $display("FAIL load_wins quotient: got %h expected 5a", bus.quotient);
      end
      n_checks++;
      if (bus.sign !== 1'b1) begin
         n_fail++;
         $display("FAIL load_wins sign (R=0 < D): got %b expected 1", bus.sign);
      end
      // Finish the division from this state to prove R=0 and D=divisor were captured.
      bus.shift = 1'b1;
      tick();
      idle_ctrl();
      iterate(q, r, signs);
      n_checks++;
      if (q !== model_q(8'h5A, 8'h33)) begin
         n_fail++;
         $display("FAIL load_wins run quotient: got %0d expected %0d", q, model_q(8'h5A, 8'h33));
      end
      n_checks++;
      if (r !== model_r(8'h5A, 8'h33)) begin
         n_fail++;
         $display("FAIL load_wins run remainder: got %0d expected %0d", r, model_r(8'h5A, 8'h33));
      end
   endtask

   task automatic test_idle();
      logic [7:0] a, b, eq, er;
      a  = 8'($urandom);
      b  = 8'($urandom_range(1, 255));
      eq = model_q(a, b);
      er = model_r(a, b);
      check_div("idle_run", a, b);
      for (int i = 0; i < 10; i++) begin
         bus.load     = 1'b0;
         bus.shift    = 1'b0;
         bus.sel      = ($urandom_range(0, 1) == 0) ? SEL_HOLD : SEL_KEEP;
         bus.add      = 1'($urandom);
         bus.inbit    = 1'($urandom);
         bus.dividend = 8'($urandom);
         bus.divisor  = 8'($urandom);
         tick();
         n_checks++;
         if (bus.quotient !== eq) begin
            n_fail++;
            $display("FAIL idle quotient cycle %0d: got %0d expected %0d", i, bus.quotient, eq);
         end
         n_checks++;
         if (bus.remainder !== er) begin
            n_fail++;
            $display("FAIL idle remainder cycle %0d: got %0d expected %0d", i, bus.remainder, er);
         end
      end
      idle_ctrl();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_mid();
      test_load_wins();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_divider_datapath
